// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history queue.
package bp_pkg;

  localparam int unsigned INDEX_W = 8;
  localparam int unsigned CNT_W   = 16;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic               pred;
  } bhq_entry_t;

  // Increment that sticks at max_value instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic [31:0] max_value);
    return (value >= max_value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/bhq_fifo.sv
// Circular buffer with extra-MSB pointers; clear empties the queue after any same-cycle pop.
module bhq_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned W     = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [PW-1:0] head_next;
  logic [PW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign count     = tail - head;
  assign full      = (count == PW'(DEPTH));
  assign empty     = (head == tail);
  assign do_push   = push && !full && !clear;
  assign do_pop    = pop && !empty;
  assign head_next = head + PW'(do_pop);
  assign dout      = mem[head[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head <= '0;
      tail <= '0;
    end else begin
      head <= head_next;
      tail <= clear ? head_next : tail + PW'(do_push);
    end
  end

  // Storage needs no reset; validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (do_push) mem[tail[AW-1:0]] <= din;
  end

endmodule

// File: rtl/branch_history_queue.sv
// Tracks in-flight predicted branches and drives predictor updates when they resolve.
module branch_history_queue
  import bp_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned INDEX_W = bp_pkg::INDEX_W,
  parameter int unsigned CNT_W   = bp_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enq_valid,
  input  logic [INDEX_W-1:0] enq_index,
  input  logic               enq_pred,
  output logic               enq_ready,
  input  logic               res_valid,
  input  logic               res_taken,
  input  logic               flush,
  output logic               update_enable,
  output logic [INDEX_W-1:0] update_index,
  output logic               outcome,
  output logic               mispredict,
  output logic [CNT_W-1:0]   resolved_cnt,
  output logic [CNT_W-1:0]   mispredict_cnt
);

  localparam int unsigned EW      = bp_pkg::INDEX_W;
  localparam logic [31:0] CNT_MAX = 32'((64'd1 << CNT_W) - 64'd1);

  bhq_entry_t enq_entry;
  bhq_entry_t head_entry;
  logic       full;
  logic       empty;
  logic       accept_res_c;
  logic       mis_c;
  logic       push_c;
  logic       clear_c;

  assign enq_entry.index = EW'(enq_index);
  assign enq_entry.pred  = enq_pred;
  assign enq_ready       = !full;

  // flush outranks resolve; a mispredict squashes all younger and same-cycle entries.
  assign accept_res_c = res_valid && !empty && !flush;
  assign mis_c        = accept_res_c && (res_taken != head_entry.pred);
  assign push_c       = enq_valid && enq_ready && !flush && !mis_c;
  assign clear_c      = flush || mis_c;

  bhq_fifo #(
    .DEPTH (DEPTH),
    .W     ($bits(bhq_entry_t))
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (accept_res_c),
    .clear (clear_c),
    .din   (enq_entry),
    .dout  (head_entry),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      update_enable  <= 1'b0;
      update_index   <= '0;
      outcome        <= 1'b0;
      mispredict     <= 1'b0;
      resolved_cnt   <= '0;
      mispredict_cnt <= '0;
    end else begin
      update_enable <= accept_res_c;
      mispredict    <= mis_c;
      if (accept_res_c) begin
        update_index <= INDEX_W'(head_entry.index);
        outcome      <= res_taken;
        resolved_cnt <= CNT_W'(sat_inc(32'(resolved_cnt), CNT_MAX));
      end
      if (mis_c) mispredict_cnt <= CNT_W'(sat_inc(32'(mispredict_cnt), CNT_MAX));
    end
  end

endmodule
